ble_tx_bit_serializer: RTL and testbench
========================================

Name: ble_tx_bit_serializer

Overview:
Downstream consumer of the BLE PHY AHB data slicer. It reads 32-bit payload words that the slicer has written into the TX buffer memory and converts them into a serial bitstream for the whitening/GFSK modulator stage. Words are sent LSB first, bytes in ascending address order. A one-word prefetch register keeps the stream free of gaps at word boundaries.

Parameters:
AD, 10, AHB byte-address width. The buffer word address is AD-2 bits, matching the slicer's fifo_address.
LEN_W, 8, width of the payload byte-length field.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request; accepted only while idle
abort  input  1  synchronous abort; forces idle
base_addr  input  AD-2  word address of the first payload word
byte_len  input  LEN_W  number of payload bytes to send
mem_read_en  output  1  buffer read strobe
mem_address  output  AD-2  buffer word address
mem_read_data  input  32  buffer read data, valid the cycle after mem_read_en (synchronous RAM)
bit_out  output  1  serial data bit
bit_valid  output  1  bit_out is valid
bit_ready  input  1  downstream accepts the bit
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at the end of a transfer

Behaviour:
- Reset (asynchronous, reset=0): state IDLE. All outputs 0, mem_address 0, all internal registers cleared. Reset in the middle of a transfer discards it and produces no done pulse.
- FSM states: IDLE, FETCH, LOAD, SHIFT, FIN.
- IDLE:
  - start=1 and byte_len≠0: latch base_addr and byte_len; set bits_left = byte_len*8 (LEN_W+3 bits wide, no overflow); go to FETCH.
  - start=1 and byte_len=0: go to FIN; no memory access.
- FETCH: mem_read_en=1 for exactly one cycle, mem_address = current word pointer; go to LOAD.
- LOAD: capture mem_read_data into the 32-bit shift register; set bit_idx=0; increment the pointer; go to SHIFT.
- SHIFT:
  - bit_valid=1 and bit_out = shreg[0].
  - On bit_valid && bit_ready: shift right by 1, bit_idx++, bits_left--.
  - While bit_valid && !bit_ready, bit_out holds stable.
- Prefetch:
  - Trigger: first SHIFT cycle of a word, when bits_left > 32.
  - Action: mem_read_en=1 for one cycle at the pointer. The next cycle captures the data into next_word, sets next_vld=1 and increments the pointer.
  - At most one outstanding prefetch at a time.
- Word boundary (handshake with bit_idx=31 and bits_left>1): load shreg from next_word and clear next_vld in the same edge, so there is no bubble. A word always takes at least 32 cycles, so next_vld is always set in time. If it is not, go to FETCH (defensive path, not expected).
- Last bit (handshake with bits_left=1): go to FIN. Partial last words send only the byte_len bytes; unused upper bytes are never output.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Timing from start sampled at edge T:
  - FETCH during cycle T+1.
  - LOAD at T+2.
  - First bit_valid at T+3.
  - done is asserted in the cycle after the last handshake.
- busy=1 in FETCH, LOAD and SHIFT; 0 in IDLE and FIN.
- start while busy is ignored.
- abort=1 in any non-IDLE state: next state IDLE; bit_valid and mem_read_en are 0 from that edge; no done; next_vld cleared. abort has priority over start and over handshakes in the same cycle.
- mem_address increments modulo 2^(AD-2) (wraps from all-ones to 0).
- mem_address holds its last value when mem_read_en=0.
- The block never writes memory. It relies on software having completed the slicer writes before start; there is no arbitration.

Decomposition:
- Shared package ble_phy_pkg holds:
  - the FSM state encoding (IDLE=0, FETCH=1, LOAD=2, SHIFT=3, FIN=4)
  - the constant WORD_BITS=32
  - the bit-order constant LSB_FIRST
- Single module. No sub-module is warranted; the shift register and prefetch register stay inline.

Test Plan:
1. base=0x10, mem[0x10]=0xA5C30F01, byte_len=4, bit_ready=1 → one read at 0x10. Bits are 1,0,0,0,0,0,0,0, 1,1,1,1,0,0,0,0, …, ending with 0xA5 LSB first. 32 contiguous bits; done pulses in the cycle after the 32nd bit.
2. byte_len=9, base=0x20 → reads at 0x20, 0x21, 0x22. 72 bits with no bit_valid gap at word boundaries; only bits 7:0 of word 0x22 are sent.
3. Same as test 2 with bit_ready random 50% → bit_out stable whenever valid && !ready; bitstream identical to test 2; done after the 72nd accepted bit.
4. start with byte_len=0 → done at T+1, mem_read_en never asserted, busy stays 0.
5. AD=10, base=0xFF, byte_len=8 → reads at 0xFF then 0x00 (wrap); 64 bits correct.
6. abort at bit 40 of test 2, and separately reset=0 at bit 40 → bit_valid=0 next cycle, no done, all outputs 0. A following start with byte_len=4 completes normally.

Source files
------------

// File: rtl/ble_phy_pkg.sv
// Shared definitions for the BLE PHY TX path.
//   state_t   : serializer FSM state encoding
//   WORD_BITS : width of one TX buffer word
//   LSB_FIRST : bit order on the serial output (1 = bit 0 of each word first)
package ble_phy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int unsigned WORD_BITS = 32;
  localparam bit          LSB_FIRST = 1'b1;

endpackage

// File: rtl/ble_tx_bit_serializer_if.sv
// Buffer read port and serial bit stream of the BLE TX bit serializer.
//   mem_read_en   : buffer read strobe (serializer -> memory)
//   mem_address   : buffer word address (serializer -> memory)
//   mem_read_data : read data, valid the cycle after mem_read_en (memory -> serializer)
//   bit_out       : serial data bit (serializer -> modulator)
//   bit_valid     : bit_out is valid (serializer -> modulator)
//   bit_ready     : modulator accepts the bit (modulator -> serializer)
// master = serializer side, slave = memory/modulator side.
interface ble_tx_bit_serializer_if #(
  parameter int AD = 10
);

  logic          mem_read_en;
  logic [AD-3:0] mem_address;
  logic [31:0]   mem_read_data;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;

  modport master (
    output mem_read_en, mem_address, bit_out, bit_valid,
    input  mem_read_data, bit_ready
  );

  modport slave (
    input  mem_read_en, mem_address, bit_out, bit_valid,
    output mem_read_data, bit_ready
  );

endinterface

// File: rtl/ble_tx_bit_serializer.sv
// BLE TX bit serializer: reads 32-bit payload words from the TX buffer and
// emits them as a serial bitstream (LSB first, ascending word addresses).
// A one-word prefetch register removes bubbles at word boundaries.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : one-cycle transfer request, accepted only when idle
//   abort     : synchronous abort, returns to idle without done
//   base_addr : word address of the first payload word
//   byte_len  : payload length in bytes (0 = empty transfer)
//   bus       : buffer read port and serial bit stream (master side)
//   busy      : transfer in progress (FETCH/LOAD/SHIFT)
//   done      : one-cycle pulse at the end of a transfer
import ble_phy_pkg::*;

module ble_tx_bit_serializer #(
  parameter int AD    = 10,
  parameter int LEN_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [AD-3:0]                 base_addr,
  input  logic [LEN_W-1:0]              byte_len,
  ble_tx_bit_serializer_if.master       bus,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = AD - 2;
  localparam int BW = LEN_W + 3;

  state_t           state, state_nxt;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    addr_q;
  logic [31:0]      shreg;
  logic [31:0]      next_word;
  logic             next_vld;
  logic             pf_pend;
  logic             first_q;
  logic [4:0]       bit_idx;
  logic [BW-1:0]    bits_left;

  logic             hs;
  logic             last_hs;
  logic             word_end;
  logic             pf_issue;
  logic             rd_en;
  logic             kill;

  assign kill     = abort && (state != IDLE);
  assign hs       = (state == SHIFT) && bus.bit_ready;
  assign last_hs  = hs && (bits_left == BW'(1));
  assign word_end = hs && (bit_idx == 5'd31) && (bits_left > BW'(1));

  // Prefetch the following word once per word, on its first shift cycle.
  assign pf_issue = (state == SHIFT) && first_q && !next_vld && !pf_pend &&
                    (bits_left > BW'(WORD_BITS));
  assign rd_en    = (state == FETCH) || pf_issue;

  // Address shows the pointer while reading and holds the last read address otherwise.
  assign bus.mem_read_en = rd_en;
  assign bus.mem_address = rd_en ? ptr : addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_out   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (byte_len == '0) ? FIN : FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy          = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_out   = LSB_FIRST ? shreg[0] : shreg[31];
        if (last_hs)                   state_nxt = FIN;
        else if (word_end && !next_vld) state_nxt = FETCH;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      addr_q    <= '0;
      shreg     <= '0;
      next_word <= '0;
      next_vld  <= 1'b0;
      pf_pend   <= 1'b0;
      first_q   <= 1'b0;
      bit_idx   <= '0;
      bits_left <= '0;
    end else begin
      if (rd_en) addr_q <= ptr;
      if (kill) begin
        next_vld <= 1'b0;
        pf_pend  <= 1'b0;
        first_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && byte_len != '0) begin
              ptr       <= base_addr;
              bits_left <= {byte_len, 3'b000};
              next_vld  <= 1'b0;
              pf_pend   <= 1'b0;
            end
          end
          LOAD: begin
            shreg   <= bus.mem_read_data;
            bit_idx <= '0;
            ptr     <= ptr + AW'(1);
            first_q <= 1'b1;
          end
          SHIFT: begin
            first_q <= 1'b0;
            pf_pend <= pf_issue;
            if (pf_pend) begin
              next_word <= bus.mem_read_data;
              next_vld  <= 1'b1;
              ptr       <= ptr + AW'(1);
            end
            if (hs) begin
              bits_left <= bits_left - BW'(1);
              bit_idx   <= bit_idx + 5'd1;
              // Seamless reload: the prefetched word replaces the drained
              // shift register on the same edge that consumes its last bit.
              if (word_end && next_vld) begin
                shreg    <= next_word;
                next_vld <= 1'b0;
                bit_idx  <= '0;
                first_q  <= 1'b1;
              end else begin
                shreg <= LSB_FIRST ? {1'b0, shreg[31:1]} : {shreg[30:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ble_tx_bit_serializer.sv
// Self-checking bench for ble_tx_bit_serializer: synchronous RAM model,
// reference bitstream/read-address lists built from the memory contents.
module tb_ble_tx_bit_serializer;

  localparam int AD    = 10;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [AD-3:0]    base_addr;
  logic [LEN_W-1:0] byte_len;
  logic             busy;
  logic             done;

  ble_tx_bit_serializer_if #(.AD(AD)) ifc ();

  ble_tx_bit_serializer #(.AD(AD), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .byte_len  (byte_len),
    .bus       (ifc.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk)
    if (ifc.mem_read_en) ifc.mem_read_data <= mem[ifc.mem_address];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer. cut_at >= 0 interrupts after that many accepted bits,
  // by abort (cut_rst=0) or by asynchronous reset (cut_rst=1).
  task automatic run(input string name, input int base, input int len, input bit rnd,
                     input int cut_at, input bit cut_rst);
    bit       exp_bits[$];
    int       exp_reads[$];
    int       reads[$];
    logic [31:0] w;
    int  cyc = 0, got = 0, first_v = -1, last_hs = -1, done_cyc = -1;
    int  done_cnt = 0, gap = 0, busy_seen = 0, post = -1, nbits;
    bit  v, o, pv = 1'b0, pr = 1'b0, po = 1'b0, cut = 1'b0;

    for (int i = 0; i < len; i++) begin
      w = mem[(base + i / 4) & 255];
      for (int b = 0; b < 8; b++) exp_bits.push_back(w[8 * (i % 4) + b]);
    end
    for (int i = 0; i < (len + 3) / 4; i++) exp_reads.push_back((base + i) & 255);
    nbits = len * 8;

    @(negedge clk);
    start         = 1'b1;
    base_addr     = base[AD-3:0];
    byte_len      = len[LEN_W-1:0];
    ifc.bit_ready = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;

    while (1) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) done_cnt++;
      if (cut) begin
        if (cyc == post + 1) begin
          if (cut_rst)
            chk({name, " reset outs"},
                {ifc.bit_valid, ifc.bit_out, ifc.mem_read_en, ifc.mem_address, busy, done}, '0);
          else
            chk({name, " abort outs"},
                {ifc.bit_valid, ifc.bit_out, ifc.mem_read_en, busy, done}, '0);
          reset = 1'b1;
          abort = 1'b0;
        end
        if (cyc >= post + 6) break;
        continue;
      end
      v = ifc.bit_valid;
      o = ifc.bit_out;
      if (ifc.mem_read_en) reads.push_back(int'(ifc.mem_address));
      if (busy) busy_seen++;
      if (done) begin
        done_cyc = cyc;
        chk({name, " busy at done"}, busy, 1'b0);
      end
      if (pv && !pr) chk({name, " hold"}, {v, o}, {1'b1, po});
      if (v && first_v < 0) first_v = cyc;
      if (first_v >= 0 && got < nbits && !v) gap++;
      if (cut_at >= 0 && got == cut_at) begin
        cut  = 1'b1;
        post = cyc;
        if (cut_rst) reset = 1'b0;
        else         abort = 1'b1;
        continue;
      end
      ifc.bit_ready = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (v && ifc.bit_ready) begin
        if (got < nbits) chk({name, " bit"}, o, exp_bits[got]);
        got++;
        if (got == nbits) last_hs = cyc;
      end
      pv = v;
      pr = ifc.bit_ready;
      po = o;
      if (done) break;
      if (cyc > 3000) begin
        vecs++;
        errs++;
        $error("FAIL %s timeout: observed no done after %0d cycles, expected done", name, cyc);
        break;
      end
    end

    if (cut) begin
      chk({name, " done after cut"}, done_cnt, 0);
    end else begin
      chk({name, " bits accepted"}, got, nbits);
      chk({name, " done count"}, done_cnt, 1);
      chk({name, " done cycle"}, done_cyc, (len == 0) ? 1 : last_hs + 1);
      if (len > 0) begin
        chk({name, " first valid latency"}, first_v, 3);
        chk({name, " valid gaps"}, gap, 0);
      end else begin
        chk({name, " busy cycles"}, busy_seen, 0);
      end
      chk({name, " read count"}, reads.size(), exp_reads.size());
      for (int i = 0; i < reads.size() && i < exp_reads.size(); i++)
        chk({name, " read addr"}, reads[i], exp_reads[i]);
    end
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    base_addr     = '0;
    byte_len      = '0;
    ifc.bit_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'hA5C30F01;

    repeat (3) @(negedge clk);
    chk("reset outs",
        {ifc.bit_valid, ifc.bit_out, ifc.mem_read_en, ifc.mem_address, busy, done}, '0);
    reset = 1'b1;

    run("t1 one word",      8'h10, 4, 1'b0, -1, 1'b0);
    run("t2 nine bytes",    8'h20, 9, 1'b0, -1, 1'b0);
    run("t3 random ready",  8'h20, 9, 1'b1, -1, 1'b0);
    run("t4 zero length",   8'h30, 0, 1'b1, -1, 1'b0);
    run("t5 address wrap",  8'hFF, 8, 1'b0, -1, 1'b0);
    run("t6 abort",         8'h20, 9, 1'b1, 40, 1'b0);
    run("t6 after abort",   8'h10, 4, 1'b0, -1, 1'b0);
    run("t6 reset",         8'h20, 9, 1'b1, 40, 1'b1);
    run("t6 after reset",   8'h10, 4, 1'b0, -1, 1'b0);
    for (int k = 0; k < 6; k++)
      run("random", int'($urandom_range(255, 0)), int'($urandom_range(40, 1)), 1'b1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
